// File: rtl/eth_helper_pkg.sv
// Shared constants and types for the AXI-channel capture stream arbiter.
// The stream type tag of a beat equals the index of the capture block that produced it.
package eth_helper_pkg;

   localparam int STREAM_TYPE_AW    = 0;
   localparam int STREAM_TYPE_W     = 1;
   localparam int STREAM_TYPE_B     = 2;
   localparam int STREAM_TYPE_AR    = 3;
   localparam int STREAM_TYPE_R     = 4;
   localparam int STREAM_TYPE_WIDTH = 3;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/eth_stream_arbiter_rr_picker.sv
// Combinational round-robin picker: the first set request found scanning
// upward from ptr with wrap-around wins.
module rr_picker #(
   parameter int N_REQ = 5,
   parameter int IDX_W = 3
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] win_oh,
   output logic [IDX_W-1:0] win_idx,
   output logic             win_any
);

   always_comb begin
      int slot;
      logic [IDX_W-1:0] slot_idx;
      win_oh   = '0;
      win_idx  = '0;
      win_any  = 1'b0;
      slot     = 0;
      slot_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         slot = int'(ptr) + k;
         if (slot >= N_REQ) slot = slot - N_REQ;
         slot_idx = IDX_W'(slot);
         if (!win_any && req[slot_idx]) begin
            win_any          = 1'b1;
            win_oh[slot_idx] = 1'b1;
            win_idx          = slot_idx;
         end
      end
   end

endmodule

// File: rtl/eth_stream_arbiter.sv
// Round-robin, packet-locked arbiter merging the AXI channel capture streams
// into one registered AXI-Stream output, with a per-grant inactivity watchdog.
module eth_stream_arbiter
   import eth_helper_pkg::*;
#(
   parameter int N_REQ             = 5,
   parameter int DATA_WIDTH        = 128,
   parameter int STREAM_TYPE_WIDTH = eth_helper_pkg::STREAM_TYPE_WIDTH,
   parameter int TIMEOUT_CYCLES    = 1024
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_REQ-1:0]             req_valid,
   input  logic [N_REQ-1:0]             req_in_progress,
   input  logic [N_REQ*DATA_WIDTH-1:0]  req_data,
   output logic [N_REQ-1:0]             req_ready,
   output logic [DATA_WIDTH-1:0]        m_axis_tdata,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic                         m_axis_tlast,
   output logic [STREAM_TYPE_WIDTH-1:0] m_axis_tuser,
   output logic                         busy,
   output logic                         err_timeout,
   output logic [31:0]                  pkt_count
);

   localparam int IDX_W = STREAM_TYPE_WIDTH;
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   arb_state_t             state, state_next;
   logic [IDX_W-1:0]       grant, ptr, ptr_after, win_idx;
   logic [N_REQ-1:0]       grant_oh, win_oh;
   logic                   win_any;
   logic [CNT_W-1:0]       wd_cnt;
   logic                   out_load, xfer, last_xfer, timeout_hit;
   logic                   sel_valid, sel_in_progress;
   logic [DATA_WIDTH-1:0]  sel_data;

   rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
      .req     (req_valid),
      .ptr     (ptr),
      .win_oh  (win_oh),
      .win_idx (win_idx),
      .win_any (win_any)
   );

   // Handshakes: a beat moves on any edge where valid & ready are both high;
   // the output register may accept a new beat only when empty or draining.
   assign out_load        = ~m_axis_tvalid | m_axis_tready;
   assign sel_valid       = req_valid[grant];
   assign sel_in_progress = req_in_progress[grant];
   assign sel_data        = req_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
   assign xfer            = (state == ARB_LOCKED) & sel_valid & out_load;
   assign last_xfer       = xfer & ~sel_in_progress;
   assign timeout_hit     = (state == ARB_LOCKED) & ~xfer &
                            (wd_cnt == CNT_W'(TIMEOUT_CYCLES-1));
   assign ptr_after       = (grant == IDX_W'(N_REQ-1)) ? '0 : grant + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) state <= ARB_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ARB_IDLE:   if (win_any) state_next = ARB_LOCKED;
         ARB_LOCKED: if (last_xfer || timeout_hit) state_next = ARB_IDLE;
         default:    state_next = ARB_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state == ARB_LOCKED);
      req_ready = (state == ARB_LOCKED && out_load) ? grant_oh : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         grant         <= '0;
         grant_oh      <= '0;
         ptr           <= '0;
         wd_cnt        <= '0;
         err_timeout   <= 1'b0;
         pkt_count     <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= '0;
      end else begin
         if (state == ARB_IDLE && win_any) begin
            grant    <= win_idx;
            grant_oh <= win_oh;
            wd_cnt   <= '0;
         end else if (state == ARB_LOCKED) begin
            if (xfer)              wd_cnt <= '0;
            else if (!timeout_hit) wd_cnt <= wd_cnt + 1'b1;
         end
         if (last_xfer) begin
            ptr       <= ptr_after;
            pkt_count <= pkt_count + 32'd1;
         end
         // A watchdog release truncates the packet: no tlast, no packet count.
         if (timeout_hit) begin
            ptr         <= ptr_after;
            err_timeout <= 1'b1;
         end
         if (out_load) begin
            m_axis_tvalid <= xfer;
            m_axis_tdata  <= sel_data;
            m_axis_tlast  <= ~sel_in_progress;
            m_axis_tuser  <= grant;
         end
      end
   end

endmodule

// File: tb/tb_eth_stream_arbiter.sv
// Randomized bench for eth_stream_arbiter: a spec-level cycle model predicts
// handshakes and status, and an expected-beat queue checks output content and order.
module tb_eth_stream_arbiter;
   import eth_helper_pkg::*;

   localparam int N  = 5;
   localparam int DW = 32;
   localparam int TW = 3;
   localparam int TO = 8;
   localparam int BW = TW + 1 + DW;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_in_progress = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    req_ready;
   logic [DW-1:0]   m_axis_tdata;
   logic            m_axis_tvalid;
   logic            m_axis_tready = 1'b0;
   logic            m_axis_tlast;
   logic [TW-1:0]   m_axis_tuser;
   logic            busy, err_timeout;
   logic [31:0]     pkt_count;

   always #5 clk = ~clk;

   eth_stream_arbiter #(
      .N_REQ(N), .DATA_WIDTH(DW), .STREAM_TYPE_WIDTH(TW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_in_progress(req_in_progress),
      .req_data(req_data), .req_ready(req_ready), .m_axis_tdata(m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .m_axis_tuser(m_axis_tuser), .busy(busy), .err_timeout(err_timeout), .pkt_count(pkt_count)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // reference model state
   bit          m_locked = 0;
   int          m_grant = 0;
   int          m_ptr = 0;
   int          m_cnt = 0;
   bit          m_tvalid = 0;
   bit          m_err = 0;
   logic [31:0] m_pkts = '0;
   bit          m_xfer = 0;
   int          m_xfer_src = 0;
   logic [BW-1:0] exp_q[$];

   // stimulus sources
   int            src_left[N];
   int            pkts_left[N];
   logic [DW-1:0] src_data[N];
   bit            src_abandon[N];
   int min_len = 1, max_len = 1, p_ready = 100, p_drop = 0, p_abandon = 0;
   bit post_reset = 0;
   int beats_out = 0;
   int obs_order[$];

   task automatic model_step();
      bit load, xfer, ip, found;
      int g;
      if (reset) begin
         m_locked = 0; m_grant = 0; m_ptr = 0; m_cnt = 0; m_tvalid = 0;
         m_err = 0; m_pkts = '0; m_xfer = 0;
         exp_q.delete();
         return;
      end
      load = !m_tvalid || m_axis_tready;
      g    = m_grant;
      xfer = m_locked && req_valid[g] && load;
      ip   = req_in_progress[g];
      m_xfer = xfer;
      m_xfer_src = g;
      if (load) m_tvalid = xfer;
      if (xfer) exp_q.push_back({TW'(g), !ip, req_data[g*DW +: DW]});
      if (!m_locked) begin
         found = 0;
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (!found && req_valid[j]) begin
               found = 1; m_grant = j; m_locked = 1; m_cnt = 0;
            end
         end
      end else if (xfer && !ip) begin
         m_locked = 0; m_ptr = (g + 1) % N; m_pkts = m_pkts + 1;
      end else if (xfer) begin
         m_cnt = 0;
      end else if (m_cnt == TO - 1) begin
         m_locked = 0; m_ptr = (g + 1) % N; m_err = 1;
      end else begin
         m_cnt++;
      end
   endtask

   task automatic start_pkt(input int i);
      if (src_left[i] == 0 && pkts_left[i] > 0) begin
         pkts_left[i]--;
         src_left[i]    = $urandom_range(max_len, min_len);
         src_data[i]    = $urandom;
         src_abandon[i] = (src_left[i] > 1) && ($urandom_range(99) < p_abandon);
      end
   endtask

   function automatic bit idle();
      bit r;
      r = !m_locked && !m_tvalid && (exp_q.size() == 0);
      for (int i = 0; i < N; i++) if (src_left[i] != 0 || pkts_left[i] != 0) r = 0;
      return r;
   endfunction

   task automatic cycle(input bit rst);
      logic [N-1:0]  exp_ready;
      logic [BW-1:0] exp_beat;
      int i;
      @(negedge clk);
      check("tvalid", m_axis_tvalid, m_tvalid);
      check("busy", busy, m_locked);
      check("err_timeout", err_timeout, m_err);
      check("pkt_count", pkt_count, m_pkts);
      if (post_reset) begin
         check("tdata_after_reset", m_axis_tdata, 0);
         check("tlast_after_reset", m_axis_tlast, 0);
         check("tuser_after_reset", m_axis_tuser, 0);
         post_reset = 0;
      end
      reset = rst;
      m_axis_tready = ($urandom_range(99) < p_ready);
      for (int s = 0; s < N; s++) begin
         start_pkt(s);
         req_valid[s]       = (src_left[s] > 0) && ($urandom_range(99) >= p_drop);
         req_in_progress[s] = (src_left[s] > 1);
         req_data[s*DW +: DW] = src_data[s];
      end
      #1;
      exp_ready = '0;
      if (m_locked && (!m_tvalid || m_axis_tready)) exp_ready[m_grant] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      if (!rst && m_axis_tvalid && m_axis_tready) begin
         if (exp_q.size() == 0) begin
            check("beat_expected", 0, 1);
         end else begin
            exp_beat = exp_q.pop_front();
            check("beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, exp_beat);
         end
         beats_out++;
         obs_order.push_back(int'(m_axis_tuser));
      end
      @(posedge clk);
      model_step();
      if (rst) post_reset = 1;
      if (m_xfer && !rst) begin
         i = m_xfer_src;
         src_left[i]--;
         src_data[i] = $urandom;
         if (src_abandon[i]) begin
            src_left[i] = 0;
            src_abandon[i] = 0;
         end
      end
   endtask

   task automatic drain(input int max_c, input string tag);
      int c;
      c = 0;
      while (!idle() && c < max_c) begin
         cycle(0);
         c++;
      end
      check(tag, idle(), 1);
   endtask

   initial begin
      int order_exp[6];
      logic [31:0] pkts_before;
      int c;
      for (int i = 0; i < N; i++) begin
         src_left[i] = 0; pkts_left[i] = 0; src_data[i] = '0; src_abandon[i] = 0;
      end
      repeat (2) @(posedge clk);
      cycle(1);
      cycle(0);

      // single requester, 3-beat packet, full throughput
      min_len = 3; max_len = 3; pkts_left[STREAM_TYPE_B] = 1;
      drain(30, "p1_drain");
      check("p1_pkt_count", pkt_count, 1);

      // three contending single-beat requesters starting from ptr 0
      cycle(1);
      min_len = 1; max_len = 1;
      pkts_left[STREAM_TYPE_AW] = 2; pkts_left[STREAM_TYPE_W] = 2; pkts_left[STREAM_TYPE_R] = 2;
      obs_order.delete();
      drain(60, "p2_drain");
      order_exp = '{STREAM_TYPE_AW, STREAM_TYPE_W, STREAM_TYPE_R,
                    STREAM_TYPE_AW, STREAM_TYPE_W, STREAM_TYPE_R};
      check("p2_order_len", obs_order.size(), 6);
      for (int k = 0; k < 6 && k < obs_order.size(); k++) check("p2_order", obs_order[k], order_exp[k]);

      // downstream backpressure in the middle of a 4-beat packet
      min_len = 4; max_len = 4; pkts_left[STREAM_TYPE_W] = 1; beats_out = 0;
      c = 0;
      while (beats_out < 2 && c < 30) begin cycle(0); c++; end
      check("p3_two_beats", beats_out, 2);
      p_ready = 0;
      repeat (5) cycle(0);
      check("p3_held_beats", beats_out, 2);
      p_ready = 100;
      drain(30, "p3_drain");
      check("p3_beats", beats_out, 4);

      // watchdog: requester 3 abandons its packet after one beat
      pkts_before = m_pkts;
      min_len = 2; max_len = 2; p_abandon = 100; pkts_left[STREAM_TYPE_AR] = 1;
      obs_order.delete();
      repeat (3) cycle(0);
      p_abandon = 0; min_len = 1; max_len = 1; pkts_left[STREAM_TYPE_R] = 1;
      drain(40, "p4_drain");
      check("p4_err_timeout", err_timeout, 1);
      check("p4_pkt_count", pkt_count, pkts_before + 32'd1);
      check("p4_order_len", obs_order.size(), 2);
      if (obs_order.size() == 2) begin
         check("p4_first", obs_order[0], STREAM_TYPE_AR);
         check("p4_next", obs_order[1], STREAM_TYPE_R);
      end

      // reset in the middle of a 4-beat packet
      min_len = 4; max_len = 4; pkts_left[STREAM_TYPE_AW] = 1;
      c = 0;
      while (!(src_left[0] == 2) && c < 30) begin cycle(0); c++; end
      check("p5_mid_packet", src_left[0], 2);
      pkts_left[STREAM_TYPE_AR] = 1;
      cycle(1);
      cycle(0);
      check("p5_err_cleared", err_timeout, 0);
      drain(60, "p5_drain");

      // randomized traffic with drops, stalls and abandoned packets
      min_len = 1; max_len = 4; p_ready = 70; p_drop = 10; p_abandon = 10;
      for (int i = 0; i < N; i++) pkts_left[i] = 20;
      drain(4000, "p6_drain");
      p_ready = 100; p_drop = 0; p_abandon = 0;

      // packet counter wrap
      force dut.pkt_count = 32'hFFFF_FFFF;
      #1;
      release dut.pkt_count;
      m_pkts = 32'hFFFF_FFFF;
      min_len = 2; max_len = 2; pkts_left[STREAM_TYPE_B] = 1;
      drain(30, "p7_drain");
      check("p7_wrap", pkt_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/eth_stream_arbiter.md
Name: eth_stream_arbiter

Overview:
- Shares one AXI-Stream output between the N_REQ AXI-channel-to-stream submodules (AW, W, B, AR, R capture blocks).
- Grants are round-robin and locked for a whole packet.
- Each output beat is registered and tagged in tuser with the source's stream type.
- A per-grant inactivity watchdog releases a stalled submodule and flags a sticky error.

Parameters:
- N_REQ, 5, number of requesting submodules
- DATA_WIDTH, 128, beat width
- STREAM_TYPE_WIDTH, 3, width of the stream type tag (must satisfy 2**STREAM_TYPE_WIDTH >= N_REQ)
- TIMEOUT_CYCLES, 1024, consecutive no-transfer cycles while locked before forced release (>=2)

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- req_valid  in  N_REQ  submodule i has a beat on req_data slice i
- req_in_progress  in  N_REQ  more beats follow the current one; 0 on the last beat
- req_data  in  N_REQ*DATA_WIDTH  slice i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  N_REQ  one-hot or zero; beat i consumed when req_valid[i] & req_ready[i]
- m_axis_tdata  out  DATA_WIDTH  output beat
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last beat of packet
- m_axis_tuser  out  STREAM_TYPE_WIDTH  index of the source submodule
- busy  out  1  FSM in LOCKED
- err_timeout  out  1  sticky watchdog flag
- pkt_count  out  32  completed packets, wraps at 2**32

Behaviour:
- Reset values: all outputs 0, ptr=0, FSM=IDLE, timeout counter=0. Reset mid-packet drops the grant immediately and discards the output register; no tlast is emitted.
- FSM IDLE:
  - If any req_valid, pick the first valid index scanning ptr, ptr+1, … N_REQ-1, 0, … ptr-1.
  - Register it as grant; go to LOCKED next cycle.
  - req_ready=0 in IDLE, so arbitration costs 1 cycle.
- FSM LOCKED:
  - req_ready[grant] = (~m_axis_tvalid | m_axis_tready); all other req_ready bits are 0.
  - Transfer xfer = req_valid[grant] & req_ready[grant].
- Output register:
  - Loads when (~m_axis_tvalid | m_axis_tready).
  - On load: tvalid=xfer, tdata=req_data[grant], tlast=~req_in_progress[grant], tuser=grant.
  - While tvalid & ~tready, all m_axis outputs hold stable.
  - Latency: beat accepted at cycle t appears on m_axis at t+1.
  - Full throughput of 1 beat/cycle within a packet.
- End of packet: xfer with req_in_progress[grant]=0 → ptr=(grant+1) mod N_REQ, pkt_count+1, go IDLE. The next grant needs at least 1 idle cycle.
- req_valid dropping mid-packet while LOCKED: grant is held, no transfer occurs, watchdog counts.
- Watchdog:
  - Counter clears on every xfer and on entry to LOCKED; otherwise increments while LOCKED.
  - At count == TIMEOUT_CYCLES-1 with no xfer: go IDLE, ptr=(grant+1) mod N_REQ, err_timeout=1 (sticky until reset).
  - pkt_count is not incremented; the output packet is truncated without tlast.
  - A downstream stall (tready=0) also counts, so the timeout covers either side stalling.
- Single-beat packet: valid=1, in_progress=0 → one beat with tlast=1.
- Simultaneous requests: only the RR winner is served; the others wait. No requester starves; its max wait is (N_REQ-1) packets.
- pkt_count wraps from 0xFFFFFFFF to 0.

Decomposition:
- Package eth_helper_pkg holds:
  - localparams STREAM_TYPE_AW=0, STREAM_TYPE_W=1, STREAM_TYPE_B=2, STREAM_TYPE_AR=3, STREAM_TYPE_R=4;
  - STREAM_TYPE_WIDTH=3;
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t.
- One sub-module, rr_picker: combinational, (req vector, ptr) → one-hot winner + index + any.

Test Plan:
- Single requester 2, 3-beat packet (in_progress 1,1,0), tready=1 → IDLE cycle, then 3 consecutive m_axis beats with tuser=2, tlast only on beat 3, pkt_count=1, ptr=3.
- Requesters 0, 1 and 4 all valid continuously with 1-beat packets, ptr=0 → grant order 0,1,4,0,1,4; each beat separated by 1 arbitration cycle.
- Backpressure: 4-beat packet, tready low for 5 cycles after beat 2 → tdata/tlast/tuser held stable, req_ready low, no beat lost or duplicated, order preserved.
- TIMEOUT_CYCLES=8, requester 3 sends 1 beat with in_progress=1 then drops valid → release after 8 no-transfer cycles, err_timeout=1, pkt_count unchanged, requester 4 served next.
- Reset asserted mid-packet (beat 2 of 4) → next cycle all outputs 0 and FSM IDLE; after reset, new arbitration starts from ptr=0.
- pkt_count preloaded near wrap via force to 0xFFFFFFFF, then one completed packet → pkt_count=0.
